// File: rtl/wb_byte_master_pkg.sv
// Shared constants and state type for the byte-stream-to-Wishbone bridge.
package wb_byte_master_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [7:0] ST_ACK   = 8'h00;
  localparam logic [7:0] ST_ERR   = 8'h01;
  localparam logic [7:0] ST_TMO   = 8'h02;
  localparam logic [7:0] ST_RTY   = 8'h03;
  localparam logic [7:0] ST_BADOP = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/wb_byte_master_shreg.sv
// 32-bit byte shift register: bytes enter at the LSB end and leave from the MSB end,
// so a word loaded MSB-first is shifted out MSB-first.
module wb_byte_master_shreg
  import wb_byte_master_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ld_word_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              ld_byte_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              shift_i,
  output logic [WORD_W-1:0] word_o
);

  logic [WORD_W-1:0] sr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr_q <= '0;
    end else if (ld_word_i) begin
      sr_q <= word_i;
    end else if (ld_byte_i) begin
      sr_q <= {sr_q[WORD_W-BYTE_W-1:0], byte_i};
    end else if (shift_i) begin
      sr_q <= {sr_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end
  end

  assign word_o = sr_q;

endmodule

// File: rtl/wb_byte_master.sv
// Byte-stream-to-Wishbone bridge: decodes host command frames into single classic
// read/write cycles and streams back a status byte plus read data.
module wb_byte_master
  import wb_byte_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic        busy_o
);

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [15:0] tmo_q;
  logic [15:0] tmo_d;
  logic        we_q;
  logic        cyc_q;
  logic [3:0]  sel_q;
  logic        rx_ready_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        busy_q;
  logic [7:0]  status_d;

  logic        rx_fire;
  logic        tx_fire;
  logic        op_ok;
  logic        term;
  logic        bus_done;
  logic        adr_ld;
  logic        dat_ld;
  logic        dat_cap;
  logic        dat_shift;
  logic [31:0] adr_word;
  logic [31:0] dat_word;

  assign rx_fire   = rx_valid_i & rx_ready_q;
  assign tx_fire   = tx_valid_q & tx_ready_i;
  assign op_ok     = (rx_data_i == OP_WRITE) || (rx_data_i == OP_READ);
  assign term      = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign tmo_d     = tmo_q + 16'd1;
  // A termination in the final allowed cycle still beats the timeout via status_d.
  assign bus_done  = term || (tmo_d == TMO_LIM);
  assign adr_ld    = rx_fire && (state_q == S_ADDR);
  assign dat_ld    = rx_fire && (state_q == S_WDATA);
  assign dat_cap   = (state_q == S_BUS) && wbm_ack_i && !we_q;
  assign dat_shift = (state_q == S_RESP) && tx_fire && (cnt_q != 3'd0);

  always_comb begin
    if (wbm_ack_i) begin
      status_d = ST_ACK;
    end else if (wbm_err_i) begin
      status_d = ST_ERR;
    end else if (wbm_rty_i) begin
      status_d = ST_RTY;
    end else begin
      status_d = ST_TMO;
    end
  end

  wb_byte_master_shreg u_adr (
    .clk_i     (wb_clk_i),
    .rst_n_i   (wb_rst_n_i),
    .ld_word_i (1'b0),
    .word_i    ('0),
    .ld_byte_i (adr_ld),
    .byte_i    (rx_data_i),
    .shift_i   (1'b0),
    .word_o    (adr_word)
  );

  // Holds the write payload going out, then the read word coming back.
  wb_byte_master_shreg u_dat (
    .clk_i     (wb_clk_i),
    .rst_n_i   (wb_rst_n_i),
    .ld_word_i (dat_cap),
    .word_i    (wbm_dat_i),
    .ld_byte_i (dat_ld),
    .byte_i    (rx_data_i),
    .shift_i   (dat_shift),
    .word_o    (dat_word)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      sel_q      <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (op_ok) begin
              we_q    <= (rx_data_i == OP_WRITE);
              state_q <= S_ADDR;
            end else begin
              rx_ready_q <= 1'b0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= ST_BADOP;
              state_q    <= S_RESP;
            end
          end
        end

        S_ADDR, S_WDATA: begin
          if (rx_fire) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd3) begin
              cnt_q <= '0;
              if ((state_q == S_ADDR) && we_q) begin
                state_q <= S_WDATA;
              end else begin
                state_q    <= S_BUS;
                rx_ready_q <= 1'b0;
                cyc_q      <= 1'b1;
                sel_q      <= 4'hF;
                tmo_q      <= '0;
              end
            end
          end
        end

        S_BUS: begin
          tmo_q <= tmo_d;
          if (bus_done) begin
            cyc_q      <= 1'b0;
            sel_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= status_d;
            cnt_q      <= dat_cap ? 3'd4 : 3'd0;
            state_q    <= S_RESP;
          end
        end

        S_RESP: begin
          // cnt_q counts response bytes still queued behind the one on tx_data_o.
          if (tx_fire) begin
            if (cnt_q == 3'd0) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              tx_data_q <= dat_word[31:24];
              cnt_q     <= cnt_q - 3'd1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign wbm_adr_o  = adr_word;
  assign wbm_dat_o  = dat_word;
  assign wbm_sel_o  = sel_q;
  assign wbm_we_o   = we_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_cti_o  = 3'b000;
  assign wbm_bte_o  = 2'b00;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_wb_byte_master.sv
// Randomized bench for wb_byte_master: host-side byte driver, Wishbone slave and
// tx sink, with responses predicted from the frame/status rules.
module tb_wb_byte_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] adr_o, dat_o;
  logic [31:0] slv_rdata = 32'h0;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;

  // slave behaviour: 0 ack, 1 err, 2 rty, 3 silent, 4 ack+err
  int slv_mode = 0;
  int slv_wait = 0;
  int tx_pol = 0;

  int          cur_len = 0, last_len = 0, bus_cnt = 0, bus_bad = 0;
  logic [31:0] cap_adr = 0, cap_dat = 0;
  logic        cap_we = 1'b0;
  bit          fin;
  int          rx_bad = 0, hold_err = 0, tx_cnt = 0;
  logic [7:0]  tx_log [4096];
  bit          stall_pend = 1'b0;
  logic [7:0]  stall_data = 8'h00;

  wb_byte_master #(.TIMEOUT(TMO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .wbm_adr_o  (adr_o),
    .wbm_dat_o  (dat_o),
    .wbm_sel_o  (sel),
    .wbm_we_o   (we),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_cti_o  (cti),
    .wbm_bte_o  (bte),
    .wbm_dat_i  (slv_rdata),
    .wbm_ack_i  (ack),
    .wbm_err_i  (err),
    .wbm_rty_i  (rty),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Wishbone slave: terminates in cycle slv_wait+1 of cyc; random noise while idle.
  always @(negedge clk) begin
    if (cyc) begin
      cur_len++;
      if (cur_len == 1) begin
        bus_cnt++;
        cap_adr = adr_o;
        cap_dat = dat_o;
        cap_we  = we;
      end else if (adr_o !== cap_adr || dat_o !== cap_dat || we !== cap_we) begin
        bus_bad++;
      end
      if (sel !== 4'hF || stb !== 1'b1 || cti !== 3'b000 || bte !== 2'b00) bus_bad++;
      fin = (slv_mode != 3) && (cur_len == slv_wait + 1);
      ack = fin && (slv_mode == 0 || slv_mode == 4);
      err = fin && (slv_mode == 1 || slv_mode == 4);
      rty = fin && (slv_mode == 2);
    end else begin
      if (cur_len != 0) begin
        last_len = cur_len;
        cur_len  = 0;
      end
      if (stb !== 1'b0) bus_bad++;
      ack = ($urandom_range(0, 3) == 0);
      err = ($urandom_range(0, 3) == 0);
      rty = ($urandom_range(0, 3) == 0);
    end
  end

  // tx sink: logs each byte committed for the coming edge, checks hold under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend && tx_valid && tx_data !== stall_data) hold_err++;
      case (tx_pol)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (tx_valid && tx_ready && tx_cnt < 4096) begin
        tx_log[tx_cnt] = tx_data;
        tx_cnt++;
      end
      stall_pend = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  always @(negedge clk) begin
    if (rst_n && (cyc || tx_valid) && rx_ready) rx_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    rx_data  = b;
    rx_valid = 1'b1;
    g = 0;
    while (!rx_ready && g < 200) begin
      step();
      g++;
    end
    if (g >= 200) chk("rx_accept_timeout", 32'd0, 32'd1);
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 3)) step();
  endtask

  function automatic logic [7:0] pick_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'($urandom);
    return (r < 4) ? 8'h01 : 8'h02;
  endfunction

  task automatic run_txn(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [31:0] rdat, input int mode, input int wt, input int pol,
                         input int nxt);
    logic [7:0] exp_q[$];
    logic [7:0] st;
    int base, bc0, bb0, rb0, he0, g, cyc_exp;
    bit is_op;
    is_op    = (op == 8'h01) || (op == 8'h02);
    slv_mode = mode;
    slv_wait = wt;
    slv_rdata = rdat;
    tx_pol   = pol;
    base = tx_cnt; bc0 = bus_cnt; bb0 = bus_bad; rb0 = rx_bad; he0 = hold_err;

    if (!is_op) begin
      exp_q.push_back(8'hFE);
    end else begin
      case (mode)
        0, 4:    st = 8'h00;
        1:       st = 8'h01;
        2:       st = 8'h03;
        default: st = 8'h02;
      endcase
      exp_q.push_back(st);
      if (op == 8'h02 && st == 8'h00)
        for (int i = 3; i >= 0; i--) exp_q.push_back(rdat[8*i +: 8]);
    end
    cyc_exp = (mode == 3) ? TMO : wt + 1;

    send_byte(op);
    if (is_op) begin
      for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8]);
      if (op == 8'h01)
        for (int i = 3; i >= 0; i--) send_byte(wdat[8*i +: 8]);
    end
    if (nxt >= 0) begin
      rx_data  = nxt[7:0];
      rx_valid = 1'b1;
    end
    g = 0;
    while ((busy || (tx_cnt - base) < exp_q.size()) && g < 400) begin
      step();
      g++;
    end
    chk("txn_done", 32'(g < 400), 32'd1);
    chk("rx_stall", 32'(rx_bad - rb0), 32'd0);
    chk("tx_hold", 32'(hold_err - he0), 32'd0);
    chk("resp_len", 32'(tx_cnt - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk("resp_byte", (i < tx_cnt - base) ? 32'(tx_log[base + i]) : 32'hDEAD, 32'(exp_q[i]));
    if (is_op) begin
      chk("bus_cnt", 32'(bus_cnt - bc0), 32'd1);
      chk("bus_adr", cap_adr, adr);
      chk("bus_we", 32'(cap_we), 32'(op == 8'h01));
      if (op == 8'h01) chk("bus_wdat", cap_dat, wdat);
      chk("cyc_len", 32'(last_len), 32'(cyc_exp));
      chk("bus_proto", 32'(bus_bad - bb0), 32'd0);
    end else begin
      chk("badop_no_cyc", 32'(bus_cnt - bc0), 32'd0);
    end
  endtask

  initial begin
    int g, base;
    logic [7:0] op, next_op;
    int nxt;

    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_tx", 32'({tx_valid, tx_data}), 32'd0);
    chk("rst_wb_ctl", 32'({cyc, stb, we, sel, cti, bte}), 32'd0);
    chk("rst_wb_adr", adr_o, 32'd0);
    chk("rst_wb_dat", dat_o, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_rx_ready", 32'(rx_ready), 32'd1);

    run_txn(8'h01, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, -1);
    run_txn(8'h02, 32'h0000_1000, 32'h0, 32'h1234_5678, 0, 3, 1, -1);
    run_txn(8'h02, 32'h0000_2000, 32'h0, 32'hAAAA_5555, 3, 0, 0, -1);
    run_txn(8'h01, 32'h0000_2004, 32'h0BAD_F00D, 32'h0, 0, 1, 0, -1);
    run_txn(8'h7F, 32'h0, 32'h0, 32'h0, 0, 0, 0, -1);
    run_txn(8'h01, 32'h8000_0000, 32'h1111_2222, 32'h0, 1, 2, 2, -1);
    run_txn(8'h02, 32'hFFFF_FFFC, 32'h0, 32'h9999_8888, 2, 1, 0, -1);
    run_txn(8'h02, 32'h0000_0040, 32'h0, 32'hC001_D00D, 4, 0, 1, -1);
    run_txn(8'h02, 32'h0000_0044, 32'h0, 32'h0F1E_2D3C, 0, TMO - 1, 0, 8'h01);
    run_txn(8'h01, 32'h0000_0048, 32'h7766_5544, 32'h0, 0, 0, 1, -1);

    next_op = pick_op();
    for (int k = 0; k < 24; k++) begin
      op = next_op;
      next_op = pick_op();
      nxt = ($urandom_range(0, 1) == 1 && k != 23) ? int'(next_op) : -1;
      run_txn(op, $urandom, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 5),
              $urandom_range(0, 2), nxt);
    end

    // Reset while a bus cycle is open.
    slv_mode = 3;
    tx_pol = 0;
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    g = 0;
    while (!cyc && g < 50) begin
      step();
      g++;
    end
    chk("pre_arst_cyc", 32'(cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc_stb", 32'({cyc, stb}), 32'd0);
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_busy_rdy", 32'({busy, rx_ready}), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rel2_rx_ready", 32'(rx_ready), 32'd1);

    // Reset partway through a 5-byte read response.
    slv_mode = 0;
    slv_wait = 3;
    slv_rdata = 32'hCAFE_F00D;
    tx_pol = 0;
    base = tx_cnt;
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h10);
    g = 0;
    while ((tx_cnt - base) < 3 && g < 100) begin
      step();
      g++;
    end
    chk("part_resp_status", 32'(tx_log[base]), 32'h00);
    chk("part_resp_d0", 32'(tx_log[base + 1]), 32'hCA);
    chk("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_cyc", 32'(cyc), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rel3_rx_ready", 32'(rx_ready), 32'd1);

    run_txn(8'h01, 32'h0000_3000, 32'h55AA_33CC, 32'h0, 0, 1, 2, -1);
    run_txn(8'h02, 32'h0000_3000, 32'h0, 32'h55AA_33CC, 0, 2, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
